// File: rtl/vta_host_pkg.sv
// Shared definitions for the VTA host CSR block: register offsets, CTRL bit positions,
// AXI response codes and channel FSM states.
package vta_host_pkg;

  localparam logic [3:0] OFF_CTRL  = 4'h0;
  localparam logic [3:0] OFF_ECNT  = 4'h4;
  localparam logic [3:0] OFF_ICNT  = 4'h8;
  localparam logic [3:0] OFF_IADDR = 4'hC;

  localparam logic [1:0] IDX_CTRL  = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_ECNT  = OFF_ECNT[3:2];
  localparam logic [1:0] IDX_ICNT  = OFF_ICNT[3:2];
  localparam logic [1:0] IDX_IADDR = OFF_IADDR[3:2];

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/vta_host_csr.sv
// AXI4-Lite register file driving launch to the VTA core and latching DONE on finish;
// counts busy cycles while START is set.
module vta_host_csr
  import vta_host_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [ADDR_BITS-1:0] s_awaddr,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  input  logic [DATA_BITS-1:0] s_wdata,
  input  logic [3:0]           s_wstrb,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  output logic [1:0]           s_bresp,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  input  logic [ADDR_BITS-1:0] s_araddr,
  output logic                 s_rvalid,
  input  logic                 s_rready,
  output logic [DATA_BITS-1:0] s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 launch,
  input  logic                 finish,
  output logic [DATA_BITS-1:0] insn_count,
  output logic [DATA_BITS-1:0] insn_addr
);

  function automatic logic [DATA_BITS-1:0] strb_merge(input logic [DATA_BITS-1:0] old_v,
                                                      input logic [DATA_BITS-1:0] new_v,
                                                      input logic [3:0]           strb);
    logic [DATA_BITS-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  wr_state_e            w_state_q;
  rd_state_e            r_state_q;
  logic                 bvalid_q;
  logic                 arready_q;
  logic                 rvalid_q;
  logic [DATA_BITS-1:0] rdata_q;

  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] ecnt_q, ecnt_d;
  logic [DATA_BITS-1:0] icnt_q, icnt_d;
  logic [DATA_BITS-1:0] iaddr_q, iaddr_d;

  logic                 wr_fire;
  logic                 wr_mapped;
  logic                 rd_mapped;
  logic [1:0]           wr_idx;
  logic [1:0]           rd_idx;
  logic [DATA_BITS-1:0] rd_val;
  logic                 unused_addr;

  assign wr_mapped   = (s_awaddr[ADDR_BITS-1:4] == '0);
  assign rd_mapped   = (s_araddr[ADDR_BITS-1:4] == '0);
  assign wr_idx      = s_awaddr[3:2];
  assign rd_idx      = s_araddr[3:2];
  assign unused_addr = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Address and data are only taken together, so a write never half-completes.
  assign wr_fire   = !reset && (w_state_q == W_IDLE) && s_awvalid && s_wvalid;
  assign s_awready = wr_fire;
  assign s_wready  = wr_fire;

  assign s_bvalid   = bvalid_q;
  assign s_bresp    = RESP_OKAY;
  assign s_arready  = arready_q;
  assign s_rvalid   = rvalid_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = RESP_OKAY;
  assign launch     = start_q;
  assign insn_count = icnt_q;
  assign insn_addr  = iaddr_q;

  always_comb begin
    start_d = start_q;
    done_d  = done_q;
    ecnt_d  = start_q ? ecnt_q + DATA_BITS'(1) : ecnt_q;
    icnt_d  = icnt_q;
    iaddr_d = iaddr_q;
    if (wr_fire && wr_mapped) begin
      case (wr_idx)
        IDX_CTRL: begin
          if (s_wstrb[0]) start_d = s_wdata[CTRL_START_BIT];
          if (s_wdata[CTRL_START_BIT]) done_d = 1'b0;
        end
        IDX_ECNT:  ecnt_d  = strb_merge(ecnt_q, s_wdata, s_wstrb);
        IDX_ICNT:  icnt_d  = strb_merge(icnt_q, s_wdata, s_wstrb);
        IDX_IADDR: iaddr_d = strb_merge(iaddr_q, s_wdata, s_wstrb);
        default: ;
      endcase
    end
    // The core's end-of-program indication outranks a racing host write.
    if (finish) begin
      start_d = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_mapped) begin
      case (rd_idx)
        IDX_CTRL: begin
          rd_val[CTRL_START_BIT] = start_q;
          rd_val[CTRL_DONE_BIT]  = done_q;
        end
        IDX_ECNT:  rd_val = ecnt_q;
        IDX_ICNT:  rd_val = icnt_q;
        IDX_IADDR: rd_val = iaddr_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ecnt_q  <= '0;
      icnt_q  <= '0;
      iaddr_q <= '0;
    end else begin
      start_q <= start_d;
      done_q  <= done_d;
      ecnt_q  <= ecnt_d;
      icnt_q  <= icnt_d;
      iaddr_q <= iaddr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_fire) begin
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // rdata is frozen at the AR handshake so a later write cannot disturb a stalled read.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s_arvalid) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vta_host_csr.sv
// Self-checking bench for vta_host_csr: table-driven register traffic plus hand-written
// launch/finish, backpressure and reset sequences; read data checked through a scoreboard.
module tb_vta_host_csr;

  logic        clock;
  logic        reset;
  logic        s_awvalid, s_awready;
  logic [15:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [15:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        launch;
  logic        finish;
  logic [31:0] insn_count;
  logic [31:0] insn_addr;

  vta_host_csr #(.ADDR_BITS(16), .DATA_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .launch(launch), .finish(finish),
    .insn_count(insn_count), .insn_addr(insn_addr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timed out", nm);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic aw_w(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st,
                      input logic br);
    logic hs;
    int   n;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    forever begin
      #1;
      hs = s_awready;
      tick();
      if (hs) break;
      n++;
      if (n > 20) begin timeout("aw_w"); break; end
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = br;
  endtask

  task automatic wait_b(input string nm);
    int n;
    n = 0;
    s_bready = 1'b1;
    while (!s_bvalid && n < 20) begin tick(); n++; end
    if (!s_bvalid) timeout(nm);
    else begin
      chk({nm, "_bresp"}, {30'b0, s_bresp}, 32'h0);
      tick();
    end
    s_bready = 1'b0;
  endtask

  task automatic axi_write(input string nm, input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] st);
    aw_w(a, d, st, 1'b1);
    wait_b(nm);
  endtask

  task automatic ar_hs(input logic [15:0] a);
    logic hs;
    int   n;
    s_araddr = a; s_arvalid = 1'b1;
    n = 0;
    forever begin
      #1;
      hs = s_arready;
      tick();
      if (hs) break;
      n++;
      if (n > 20) begin timeout("ar"); break; end
    end
    s_arvalid = 1'b0;
  endtask

  task automatic r_collect(input string nm);
    logic [31:0] e;
    int          n;
    n = 0;
    s_rready = 1'b1;
    while (!s_rvalid && n < 20) begin tick(); n++; end
    if (!s_rvalid) begin
      timeout(nm);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk(nm, s_rdata, e);
      chk({nm, "_rresp"}, {30'b0, s_rresp}, 32'h0);
      tick();
    end
    s_rready = 1'b0;
  endtask

  task automatic axi_read(input string nm, input logic [15:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    ar_hs(a);
    r_collect(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; finish = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b0; s_arvalid = 1'b0; s_araddr = '0; s_rready = 1'b0;

    vt[0]  = '{1'b0, 16'h0000, 32'h0,         4'h0, 32'h0000_0000};
    vt[1]  = '{1'b0, 16'h0004, 32'h0,         4'h0, 32'h0000_0000};
    vt[2]  = '{1'b0, 16'h0008, 32'h0,         4'h0, 32'h0000_0000};
    vt[3]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 32'h0000_0000};
    vt[4]  = '{1'b1, 16'h0008, 32'h1,         4'hF, 32'h0};
    vt[5]  = '{1'b1, 16'h000C, 32'hFFFC_0000, 4'hF, 32'h0};
    vt[6]  = '{1'b0, 16'h0008, 32'h0,         4'h0, 32'h0000_0001};
    vt[7]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 32'hFFFC_0000};
    vt[8]  = '{1'b1, 16'h000C, 32'hFFFF_FFFF, 4'h3, 32'h0};
    vt[9]  = '{1'b0, 16'h000C, 32'h0,         4'h0, 32'hFFFC_FFFF};
    vt[10] = '{1'b0, 16'h0040, 32'h0,         4'h0, 32'h0000_0000};
    vt[11] = '{1'b1, 16'h001C, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vt[12] = '{1'b0, 16'h000C, 32'h0,         4'h0, 32'hFFFC_FFFF};
    vt[13] = '{1'b0, 16'h000E, 32'h0,         4'h0, 32'hFFFC_FFFF};
    vt[14] = '{1'b1, 16'h0004, 32'h1234_5678, 4'hF, 32'h0};
    vt[15] = '{1'b0, 16'h0004, 32'h0,         4'h0, 32'h1234_5678};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_launch",  {31'b0, launch},    32'h0);
    chk("rst_bvalid",  {31'b0, s_bvalid},  32'h0);
    chk("rst_rvalid",  {31'b0, s_rvalid},  32'h0);
    chk("rst_arready", {31'b0, s_arready}, 32'h0);
    chk("rst_rdata",   s_rdata,            32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) axi_write($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb);
      else          axi_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
    end
    chk("port_insn_addr",  insn_addr,  32'hFFFC_FFFF);
    chk("port_insn_count", insn_count, 32'h0000_0001);

    // Busy-cycle count across a 100-cycle run, then finish.
    axi_write("ecnt_clr", 16'h0004, 32'h0, 4'hF);
    aw_w(16'h0000, 32'h1, 4'hF, 1'b1);
    chk("run_launch_on", {31'b0, launch}, 32'h1);
    repeat (99) @(posedge clock);
    #1;
    finish = 1'b1;
    chk("run_launch_pre", {31'b0, launch}, 32'h1);
    tick();
    finish = 1'b0;
    s_bready = 1'b0;
    chk("run_launch_off", {31'b0, launch}, 32'h0);
    axi_read("run_ctrl", 16'h0000, 32'h2);
    axi_read("run_ecnt", 16'h0004, 32'd100);

    // CTRL write colliding with finish.
    axi_write("col_set", 16'h0000, 32'h1, 4'hF);
    axi_write("col_clr", 16'h0000, 32'h0, 4'hF);
    axi_read("col_ctrl0", 16'h0000, 32'h0);
    s_awaddr = 16'h0000; s_wdata = 32'h1; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; finish = 1'b1;
    #1;
    chk("col_awready", {31'b0, s_awready}, 32'h1);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; finish = 1'b0;
    wait_b("col_b");
    chk("col_launch", {31'b0, launch}, 32'h0);
    axi_read("col_ctrl", 16'h0000, 32'h2);
    axi_write("col_rearm", 16'h0000, 32'h1, 4'hF);
    chk("col_launch1", {31'b0, launch}, 32'h1);
    axi_read("col_ctrl1", 16'h0000, 32'h1);
    axi_write("col_stop", 16'h0000, 32'h0, 4'hF);

    // Counter wrap: FFFF_FFFF -> 0 -> 1 over the two busy edges.
    axi_write("wrap_ld", 16'h0004, 32'hFFFF_FFFF, 4'hF);
    aw_w(16'h0000, 32'h1, 4'hF, 1'b1);
    aw_w(16'h0000, 32'h0, 4'hF, 1'b1);
    wait_b("wrap_b");
    axi_read("wrap_ecnt", 16'h0004, 32'h1);

    // Write response held off: no second accept, response stays up.
    aw_w(16'h0008, 32'h55, 4'hF, 1'b0);
    s_awaddr = 16'h0008; s_wdata = 32'hAA; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_bvalid%0d", i),  {31'b0, s_bvalid},  32'h1);
      chk($sformatf("bp_awready%0d", i), {31'b0, s_awready}, 32'h0);
      tick();
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b("bp_b");
    axi_read("bp_icnt", 16'h0008, 32'h55);

    // Read data held off while the register underneath changes.
    exp_q.push_back(32'h55);
    ar_hs(16'h0008);
    axi_write("rbp_wr", 16'h0008, 32'h77, 4'hF);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rbp_rvalid%0d", i),  {31'b0, s_rvalid},  32'h1);
      chk($sformatf("rbp_rdata%0d", i),   s_rdata,            32'h55);
      chk($sformatf("rbp_arready%0d", i), {31'b0, s_arready}, 32'h0);
      tick();
    end
    r_collect("rbp_pop");
    axi_read("rbp_icnt", 16'h0008, 32'h77);

    // Reset with both channels mid-transaction.
    axi_write("mr_start", 16'h0000, 32'h1, 4'hF);
    chk("mr_launch1", {31'b0, launch}, 32'h1);
    aw_w(16'h0008, 32'h99, 4'hF, 1'b0);
    ar_hs(16'h000C);
    chk("mr_bvalid1", {31'b0, s_bvalid}, 32'h1);
    chk("mr_rvalid1", {31'b0, s_rvalid}, 32'h1);
    reset = 1'b1;
    tick();
    chk("mr_bvalid0", {31'b0, s_bvalid}, 32'h0);
    chk("mr_rvalid0", {31'b0, s_rvalid}, 32'h0);
    chk("mr_launch0", {31'b0, launch},   32'h0);
    chk("mr_rdata0",  s_rdata,           32'h0);
    reset = 1'b0;
    axi_read("mr_icnt", 16'h0008, 32'h0);
    axi_read("mr_ctrl", 16'h0000, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
